// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
//   Shared elaboration-time helpers for the CIC interpolator.
//   - clog2_f      : ceiling log2 of a positive integer
//   - acc_w_f      : internal comb/integrator width, DATA_WIDTH + N*log2(R)
//   - shift_f      : output slice offset, (N-1)*log2(R), which removes the
//                    R^(N-1) passband gain of the interpolator
//   - params_ok_f  : legal parameter range (R power of two in 2..64, N in 1..6)
// -----------------------------------------------------------------------------
package cic_pkg;

  function automatic int clog2_f(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  function automatic int acc_w_f(input int data_width, input int r, input int n);
    return data_width + n * clog2_f(r);
  endfunction

  function automatic int shift_f(input int data_width, input int r, input int n);
    // data_width is unused in the formula but kept so all sizing helpers share
    // one call signature.
    return (n - 1) * clog2_f(r) + (data_width - data_width);
  endfunction

  function automatic bit params_ok_f(input int data_width, input int r, input int n);
    return (data_width >= 2) && (r >= 2) && (r <= 64) && ((r & (r - 1)) == 0) &&
           (n >= 1) && (n <= 6);
  endfunction

endpackage

// File: rtl/cic_interpolator_stage.sv
// -----------------------------------------------------------------------------
// cic_integrator_stage
//   One integrator of the high-rate section: acc_o <= acc_o + data_i on every
//   ena_i cycle. Arithmetic wraps modulo 2^WIDTH, which the CIC structure
//   relies on (the final result is exact despite intermediate wrap).
// Ports
//   clk_i   rising-edge clock
//   rst_i   asynchronous active-high reset, clears the accumulator
//   ena_i   high-rate sample enable; accumulator frozen when low
//   data_i  WIDTH-bit addend (upsampled comb output or previous integrator)
//   acc_o   registered accumulator value
// -----------------------------------------------------------------------------
module cic_integrator_stage
  import cic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] acc_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_o <= '0;
    end else if (ena_i) begin
      acc_o <= acc_o + data_i;
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// -----------------------------------------------------------------------------
// cic_interpolator
//   CIC interpolation filter: N comb stages at the low rate, zero-stuffing
//   upsampler by R, N integrators at the high rate, and a gain-normalising
//   slice back to DATA_WIDTH.
// Parameters
//   DATA_WIDTH  signed sample width (default 8)
//   R           interpolation ratio, power of two 2..64 (default 4)
//   N           comb / integrator stage count, 1..6 (default 3)
// Ports
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-high reset
//   ena_i       high-rate enable, one output sample per ena_i cycle
//   data_i      signed low-rate input sample
//   data_req_o  input request strobe (combinational)
//   data_o      signed output sample (registered)
//   valid_o     registered copy of ena_i
// Build option
//   CIC_INTERP_ROUND_EN  when defined, round half up before the output slice;
//                        otherwise truncate (floor).
// -----------------------------------------------------------------------------
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int R          = 4,
  parameter int N          = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ena_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  data_req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  localparam int LOG2R = clog2_f(R);
  localparam int ACC_W = acc_w_f(DATA_WIDTH, R, N);
  localparam int SHIFT = shift_f(DATA_WIDTH, R, N);

  if (!params_ok_f(DATA_WIDTH, R, N)) begin : g_param_check
    $error("cic_interpolator: unsupported DATA_WIDTH/R/N combination");
  end

  logic [LOG2R-1:0] phase_q;
  logic             capture;
  logic             stuff_tick;
  logic [ACC_W-1:0] x_q;
  logic [ACC_W-1:0] d_q    [N];
  logic [ACC_W-1:0] d_next [N];
  logic [ACC_W-1:0] comb_out;
  logic [ACC_W-1:0] u;
  logic [N-1:0][ACC_W-1:0] integ_q;
  logic [ACC_W-1:0] out_pre;
  logic [DATA_WIDTH-1:0] out_slice;
  logic             unused_out_bits;

  // Request handshake: the block pulls samples itself. data_req_o is high in
  // exactly the cycle data_i is sampled (ena_i with phase 0, outside reset);
  // upstream must present a valid data_i whenever data_req_o is high and
  // there is no back-pressure path.
  assign capture    = ena_i & (phase_q == '0);
  assign stuff_tick = ena_i & (phase_q == LOG2R'(1));
  assign data_req_o = capture & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= '0;
      x_q     <= '0;
      for (int j = 0; j < N; j++) d_q[j] <= '0;
    end else begin
      if (ena_i) phase_q <= phase_q + LOG2R'(1);
      if (capture) begin
        x_q <= {{(ACC_W - DATA_WIDTH){data_i[DATA_WIDTH-1]}}, data_i};
        // Delays take the comb taps as seen before x_q updates.
        for (int j = 0; j < N; j++) d_q[j] <= d_next[j];
      end
    end
  end

  // Comb chain: c0 = x_q, c_j = c_{j-1} - d_j. d_next[j] is c_j's input tap.
  always_comb begin
    logic [ACC_W-1:0] comb_run;
    d_next   = '{default: '0};
    comb_run = x_q;
    for (int j = 0; j < N; j++) begin
      d_next[j] = comb_run;
      comb_run  = comb_run - d_q[j];
    end
    comb_out = comb_run;
  end

  // Zero stuffing: the comb result enters the integrators once per R ticks,
  // on the first tick after the capture so the new x_q is already visible.
  assign u = stuff_tick ? comb_out : '0;

  for (genvar k = 0; k < N; k++) begin : g_integ
    logic [ACC_W-1:0] stage_in;
    if (k == 0) begin : g_first
      assign stage_in = u;
    end else begin : g_chain
      assign stage_in = integ_q[k-1];
    end
    cic_integrator_stage #(
      .WIDTH (ACC_W)
    ) u_stage (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .ena_i  (ena_i),
      .data_i (stage_in),
      .acc_o  (integ_q[k])
    );
  end

`ifdef CIC_INTERP_ROUND_EN
  // Half an output LSB; evaluates to zero when SHIFT is zero.
  localparam logic [ACC_W-1:0] ROUND_BIAS = ACC_W'((1 << SHIFT) >> 1);
  assign out_pre = integ_q[N-1] + ROUND_BIAS;
`else
  assign out_pre = integ_q[N-1];
`endif

  // The impulse response is all-positive with sum R^N, so after dividing by
  // R^(N-1) the result always fits DATA_WIDTH; the upper bits are redundant.
  assign out_slice       = out_pre[SHIFT +: DATA_WIDTH];
  assign unused_out_bits = ^out_pre;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= ena_i;
      if (ena_i) data_o <= out_slice;
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
module tb_cic_interpolator;

  localparam int DW       = 8;
  localparam int ND       = 3;
  localparam int P_N [ND] = '{3, 1, 5};
  localparam int P_R [ND] = '{4, 2, 16};
  localparam int XS_DEPTH = 16384;
  localparam int H_DEPTH  = 128;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;
  logic ena;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] din  [ND];
  logic [DW-1:0] dout [ND];
  logic          vld  [ND];
  logic          req  [ND];

  cic_interpolator #(.DATA_WIDTH(DW), .R(P_R[0]), .N(P_N[0])) u_dut0 (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .data_i(din[0]),
    .data_req_o(req[0]), .data_o(dout[0]), .valid_o(vld[0]));

  cic_interpolator #(.DATA_WIDTH(DW), .R(P_R[1]), .N(P_N[1])) u_dut1 (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .data_i(din[1]),
    .data_req_o(req[1]), .data_o(dout[1]), .valid_o(vld[1]));

  cic_interpolator #(.DATA_WIDTH(DW), .R(P_R[2]), .N(P_N[2])) u_dut2 (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .data_i(din[2]),
    .data_req_o(req[2]), .data_o(dout[2]), .valid_o(vld[2]));

  // ---------------------------------------------------------------- scoreboard
  int            n_checks;
  int            n_errors;
  int            tcnt;
  int            req_seen0;
  longint        xs [ND][XS_DEPTH];
  longint        hh [ND][H_DEPTH];
  int            hlen [ND];
  longint        last_exp [ND];
  logic [DW-1:0] exp_q [$];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (tick %0d)", tag, got, exp, tcnt);
    end
  endtask

  // Impulse response of the interpolator = coefficients of (1+z+..+z^(R-1))^N.
  function automatic void build_h();
    longint tmp [H_DEPTH];
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < H_DEPTH; i++) hh[d][i] = 0;
      hh[d][0] = 1;
      hlen[d]  = 1;
      for (int s = 0; s < P_N[d]; s++) begin
        for (int i = 0; i < H_DEPTH; i++) tmp[i] = 0;
        for (int i = 0; i < hlen[d]; i++)
          for (int k = 0; k < P_R[d]; k++) tmp[i+k] += hh[d][i];
        hlen[d] += P_R[d] - 1;
        for (int i = 0; i < H_DEPTH; i++) hh[d][i] = tmp[i];
      end
    end
  endfunction

  // Output produced on ena tick t: zero-stuffed input convolved with h,
  // delayed N+1 ticks, divided by R^(N-1) (floor, or round half up).
  function automatic longint ref_out(input int d, input int t);
    longint acc;
    int     base, m_lo, m_hi, sh;
    acc  = 0;
    base = t - P_N[d] - 1;
    sh   = (P_N[d] - 1) * $clog2(P_R[d]);
    if (base >= 0) begin
      m_hi = base / P_R[d];
      m_lo = base - (hlen[d] - 1);
      m_lo = (m_lo <= 0) ? 0 : (m_lo + P_R[d] - 1) / P_R[d];
      for (int m = m_lo; m <= m_hi; m++)
        acc += xs[d][m] * hh[d][base - m * P_R[d]];
    end
`ifdef CIC_INTERP_ROUND_EN
    if (sh > 0) acc += longint'(1) <<< (sh - 1);
`endif
    return acc >>> sh;
  endfunction

  function automatic void model_reset();
    tcnt      = 0;
    req_seen0 = 0;
    for (int d = 0; d < ND; d++) begin
      last_exp[d] = 0;
      for (int m = 0; m < XS_DEPTH; m++) xs[d][m] = 0;
    end
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic rand_others();
    for (int d = 1; d < ND; d++) din[d] = DW'($urandom_range(0, 255));
  endtask

  task automatic cycle(input logic en);
    ena = en;
    #1;
    for (int d = 0; d < ND; d++)
      check_eq($sformatf("req%0d", d), longint'(req[d]),
               longint'(en && (tcnt % P_R[d] == 0)));
    if (req[0]) req_seen0++;
    @(posedge clk);
    if (en) begin
      for (int d = 0; d < ND; d++) begin
        if ((tcnt % P_R[d] == 0) && (tcnt / P_R[d] < XS_DEPTH))
          xs[d][tcnt / P_R[d]] = longint'($signed(din[d]));
        last_exp[d] = ref_out(d, tcnt);
      end
      tcnt++;
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("valid%0d", d), longint'(vld[d]), longint'(en));
      check_eq($sformatf("data%0d", d), longint'($signed(dout[d])), last_exp[d]);
    end
  endtask

  task automatic check_zero_state(input string tag);
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("%s_data%0d", tag, d), longint'(dout[d]), 0);
      check_eq($sformatf("%s_valid%0d", tag, d), longint'(vld[d]), 0);
      check_eq($sformatf("%s_req%0d", tag, d), longint'(req[d]), 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_zero_state("rst");
    rst = 1'b0;
    model_reset();
  endtask

  // Pulse of amplitude amp on the first capture, zeros afterwards.
  task automatic run_pulse(input string tag, input logic [DW-1:0] amp,
                           input bit gapped, input int ticks);
    int   cyc;
    logic en;
    cyc = 0;
    while (tcnt < ticks && cyc < ticks * 20) begin
      din[0] = (tcnt == 0) ? amp : '0;
      rand_others();
      en = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(en);
      cyc++;
      if (en && exp_q.size() > 0)
        check_eq(tag, longint'($signed(dout[0])), longint'($signed(exp_q.pop_front())));
    end
    check_eq({tag, "_left"}, longint'(exp_q.size()), 0);
    check_eq({tag, "_reqs"}, longint'(req_seen0), longint'((ticks + 3) / 4));
  endtask

  task automatic push_pulse(input int v [10]);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back('0);
    for (int i = 0; i < 10; i++) exp_q.push_back(DW'(v[i]));
    for (int i = 0; i < 6; i++) exp_q.push_back('0);
  endtask

  task automatic run_dc(input string tag, input int value);
    do_reset();
    for (int i = 0; i < 80; i++) begin
      din[0] = DW'(value);
      rand_others();
      cycle(1'b1);
    end
    check_eq(tag, longint'($signed(dout[0])), longint'(value));
  endtask

  // ---------------------------------------------------------------- stimulus
  int imp64  [10] = '{4, 12, 24, 40, 48, 48, 40, 24, 12, 4};
`ifdef CIC_INTERP_ROUND_EN
  int imp1   [10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
`else
  int imp1   [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    ena      = 1'b0;
    for (int d = 0; d < ND; d++) din[d] = '0;
    build_h();
    model_reset();

    // Impulse, continuous enable.
    do_reset();
    push_pulse(imp64);
    run_pulse("imp", 8'd64, 1'b0, 24);

    // Same impulse with ~50% enable duty.
    do_reset();
    push_pulse(imp64);
    run_pulse("gap", 8'd64, 1'b1, 24);

    // DC extremes.
    run_dc("dc_100", 100);
    run_dc("dc_neg128", -128);
    run_dc("dc_127", 127);

    // Reset in the middle of the impulse tail, then a clean restart.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      din[0] = (tcnt == 0) ? 8'd64 : 8'd0;
      rand_others();
      cycle(1'b1);
    end
    check_eq("pre_rst_nonzero", longint'(dout[0] != '0), 1);
    rst = 1'b1;
    ena = 1'b1;
    #1;
    check_zero_state("async_rst");
    @(negedge clk);
    check_zero_state("mid_rst");
    rst = 1'b0;
    model_reset();
    push_pulse(imp64);
    run_pulse("restart", 8'd64, 1'b0, 24);

    // Unit impulse exercises the rounding/truncation choice.
    do_reset();
    push_pulse(imp1);
    run_pulse("round", 8'd1, 1'b0, 24);

    // Random samples and enable gaps against the reference model.
    do_reset();
    begin
      int cyc;
      cyc = 0;
      while (tcnt < 10000 && cyc < 40000) begin
        for (int d = 0; d < ND; d++) begin
          case ($urandom_range(0, 7))
            0:       din[d] = 8'h7f;
            1:       din[d] = 8'h80;
            default: din[d] = DW'($urandom_range(0, 255));
          endcase
        end
        cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        cyc++;
      end
      check_eq("rand_ticks", longint'(tcnt), 10000);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
